// File: rtl/multicycle_controller.sv
// multicycle_controller: registered T0..T3 sequencer, instruction register and go/done handshake for the shared-bus datapath.
// Optional illegal-instruction trap state: define MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN.
`default_nettype none

module multicycle_controller #(
  parameter int DATA_W = 10,
  parameter int REG_AW = 2,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [DATA_W-1:0] inst_in,
  output logic [DATA_W-1:0] IMM,
  output logic              ImmOut,
  output logic [REG_AW-1:0] Rin,
  output logic [REG_AW-1:0] Rout,
  output logic              ENW,
  output logic              ENR,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic [OP_W-1:0]   ALUcont,
  output logic              Ext,
  output logic              IRin,
  output logic              Clr,
  output logic [1:0]        T,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);

  localparam int IMM_W = DATA_W - 2 - REG_AW;

  localparam logic [2:0] S_T0   = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
  localparam logic [2:0] S_TRAP = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [DATA_W-1:0] r_ir;

  logic [1:0]        w_cls;
  logic [REG_AW-1:0] w_rx;
  logic [REG_AW-1:0] w_ry;
  logic [OP_W-1:0]   w_op;
  logic [IMM_W-1:0]  w_imm;
  logic              w_is_ld;
  logic              w_is_cp;
  logic              w_illegal;
  logic              w_fetch;

  assign w_cls     = r_ir[DATA_W-1 -: 2];
  assign w_rx      = r_ir[DATA_W-3 -: REG_AW];
  assign w_ry      = r_ir[DATA_W-3-REG_AW -: REG_AW];
  assign w_op      = r_ir[OP_W-1:0];
  assign w_imm     = r_ir[IMM_W-1:0];
  assign w_is_ld   = (w_cls == 2'b00) && (w_op == OP_W'(0));
  assign w_is_cp   = (w_cls == 2'b00) && (w_op == OP_W'(1));
  assign w_illegal = (w_cls == 2'b01) || ((w_cls == 2'b00) && (w_op >= OP_W'(12)));
  // Gated with rst_n so that no bus driver or strobe shows while reset is held.
  assign w_fetch   = (r_state == S_T0) && go && rst_n;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_T0: if (go) w_next = S_T1;
      S_T1: begin
        if (w_is_ld || w_is_cp) begin
          w_next = S_T0;
        end else if (w_illegal) begin
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
          w_next = S_TRAP;
`else
          w_next = S_T0;
`endif
        end else begin
          w_next = S_T2;
        end
      end
      S_T2:   w_next = S_T3;
      S_T3:   w_next = S_T0;
      S_TRAP: if (err_clr) w_next = S_T0;
      default: w_next = S_T0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_T0;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (w_fetch) r_ir <= inst_in;
    end
  end

`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((r_state == S_T1) && w_illegal) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign err = r_err;
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = err_clr;
  assign err = 1'b0;
`endif

  always_comb begin
    IMM     = '0;
    ImmOut  = 1'b0;
    Rin     = '0;
    Rout    = '0;
    ENW     = 1'b0;
    ENR     = 1'b0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    ALUcont = '0;
    Ext     = 1'b0;
    IRin    = 1'b0;
    Clr     = 1'b0;
    case (r_state)
      S_T0: begin
        Ext  = w_fetch;
        IRin = w_fetch;
      end
      S_T1: begin
        if (w_is_ld) begin
          Ext = 1'b1;
          Rin = w_rx;
          ENW = 1'b1;
          Clr = 1'b1;
        end else if (w_is_cp) begin
          Rout = w_ry;
          ENR  = 1'b1;
          Rin  = w_rx;
          ENW  = 1'b1;
          Clr  = 1'b1;
        end else if (w_illegal) begin
`ifndef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
          Clr = 1'b1;
`endif
        end else begin
          // inv/flp also load A here; the ALU ignores it for those ops.
          Rout = w_rx;
          ENR  = 1'b1;
          Ain  = 1'b1;
        end
      end
      S_T2: begin
        Gin = 1'b1;
        if (w_cls == 2'b00) begin
          Rout    = w_ry;
          ENR     = 1'b1;
          ALUcont = w_op;
        end else begin
          IMM     = {{(DATA_W-IMM_W){1'b0}}, w_imm};
          ImmOut  = 1'b1;
          ALUcont = (w_cls == 2'b10) ? OP_W'(2) : OP_W'(3);
        end
      end
      S_T3: begin
        Gout = 1'b1;
        Rin  = w_rx;
        ENW  = 1'b1;
        Clr  = 1'b1;
      end
      default: ;
    endcase
  end

  assign T    = r_state[1:0];
  assign busy = (r_state == S_T1) || (r_state == S_T2) || (r_state == S_T3);

  a_one_bus_driver: assert property (@(posedge clk) disable iff (!rst_n)
    $countones({Ext, ENR, Gout, ImmOut}) <= 1);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed self-checking bench for multicycle_controller (DATA_W=10, REG_AW=2, OP_W=4).
`default_nettype none

module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       go = 1'b0;
  logic       err_clr = 1'b0;
  logic [9:0] inst_in = '0;

  logic [9:0] IMM;
  logic       ImmOut, ENW, ENR, Ain, Gin, Gout, Ext, IRin, Clr, busy, err;
  logic [1:0] Rin, Rout, T;
  logic [3:0] ALUcont;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] LD   = 10'b00_01_00_0000;
  localparam logic [9:0] ADD  = 10'b00_10_11_0010;
  localparam logic [9:0] SUBI = 10'b11_01_101101;
  localparam logic [9:0] CP1  = 10'b00_01_10_0001;
  localparam logic [9:0] CP2  = 10'b00_11_00_0001;
  localparam logic [9:0] ILL  = 10'b01_00_000000;

  multicycle_controller #(.DATA_W(10), .REG_AW(2), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .inst_in(inst_in),
    .IMM(IMM), .ImmOut(ImmOut), .Rin(Rin), .Rout(Rout), .ENW(ENW), .ENR(ENR),
    .Ain(Ain), .Gin(Gin), .Gout(Gout), .ALUcont(ALUcont), .Ext(Ext), .IRin(IRin),
    .Clr(Clr), .T(T), .busy(busy), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  logic [30:0] obs;
  assign obs = {IMM, ImmOut, Rin, Rout, ENW, ENR, Ain, Gin, Gout, ALUcont, Ext, IRin, Clr, T, busy, err};

  function automatic logic [30:0] mk(input logic [9:0] imm, input logic imo,
                                     input logic [1:0] rin, input logic [1:0] rout,
                                     input logic enw, input logic enr, input logic ain,
                                     input logic gin, input logic gout, input logic [3:0] alu,
                                     input logic ext, input logic irin, input logic clr,
                                     input logic [1:0] t, input logic bsy, input logic er);
    return {imm, imo, rin, rout, enw, enr, ain, gin, gout, alu, ext, irin, clr, t, bsy, er};
  endfunction

  localparam logic [30:0] ZERO  = '0;
  localparam logic [30:0] FETCH = 31'b00000_00000_0_00_00_0_0_0_0_0_0000_1_1_0_00_0_0;

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($countones({Ext, ENR, Gout, ImmOut}) > 1) begin
        errors++;
        $display("FAIL bus_driver t=%0t drivers=%b required at most one", $time, {Ext, ENR, Gout, ImmOut});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; go = 1'b1; inst_in = LD;
    tick(); tick();
    #1;
    checks++;
    if (obs !== ZERO) begin errors++; $display("FAIL reset_held: got %h required %h", obs, ZERO); end
    tick();
    go = 1'b0; rst_n = 1'b1;
    #1;
    checks++;
    if (obs !== ZERO) begin errors++; $display("FAIL reset_release: got %h required %h", obs, ZERO); end
    tick();
  endtask

  task automatic test_ld();
    logic [30:0] e [3];
    logic        g [3];
    e[0] = FETCH;                                                g[0] = 1;
    e[1] = mk(0, 0, 2'd1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0); g[1] = 0;
    e[2] = ZERO;                                                 g[2] = 0;
    for (int c = 0; c < 3; c++) begin
      go = g[c]; inst_in = LD;
      #1;
      checks++;
      if (obs !== e[c]) begin errors++; $display("FAIL ld cyc%0d: got %h required %h", c, obs, e[c]); end
      tick();
    end
  endtask

  task automatic test_add();
    logic [30:0] e [5];
    e[0] = FETCH;
    e[1] = mk(0, 0, 0, 2'd2, 0, 1, 1, 0, 0, 4'd0, 0, 0, 0, 1, 1, 0);
    e[2] = mk(0, 0, 0, 2'd3, 0, 1, 0, 1, 0, 4'd2, 0, 0, 0, 2, 1, 0);
    e[3] = mk(0, 0, 2'd2, 0, 1, 0, 0, 0, 1, 4'd0, 0, 0, 1, 3, 1, 0);
    e[4] = ZERO;
    for (int c = 0; c < 5; c++) begin
      go = (c == 0); inst_in = ADD;
      #1;
      checks++;
      if (obs !== e[c]) begin errors++; $display("FAIL add cyc%0d: got %h required %h", c, obs, e[c]); end
      tick();
    end
  endtask

  task automatic test_subi();
    logic [30:0] e [5];
    e[0] = FETCH;
    e[1] = mk(0, 0, 0, 2'd1, 0, 1, 1, 0, 0, 4'd0, 0, 0, 0, 1, 1, 0);
    e[2] = mk(10'd45, 1, 0, 0, 0, 0, 0, 1, 0, 4'd3, 0, 0, 0, 2, 1, 0);
    e[3] = mk(0, 0, 2'd1, 0, 1, 0, 0, 0, 1, 4'd0, 0, 0, 1, 3, 1, 0);
    e[4] = ZERO;
    for (int c = 0; c < 5; c++) begin
      go = (c == 0); inst_in = SUBI;
      #1;
      checks++;
      if (obs !== e[c]) begin errors++; $display("FAIL subi cyc%0d: got %h required %h", c, obs, e[c]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [30:0] e [5];
    logic [9:0]  iv [5];
    e[0] = FETCH;                                                   iv[0] = CP1;
    e[1] = mk(0, 0, 2'd1, 2'd2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0); iv[1] = CP2;
    e[2] = FETCH;                                                   iv[2] = CP2;
    e[3] = mk(0, 0, 2'd3, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0); iv[3] = LD;
    e[4] = ZERO;                                                    iv[4] = LD;
    for (int c = 0; c < 5; c++) begin
      go = (c < 4); inst_in = iv[c];
      #1;
      checks++;
      if (obs !== e[c]) begin errors++; $display("FAIL b2b_cp cyc%0d: got %h required %h", c, obs, e[c]); end
      tick();
    end
  endtask

  task automatic test_go_ignored();
    logic [30:0] e [5];
    e[0] = FETCH;
    e[1] = mk(0, 0, 0, 2'd2, 0, 1, 1, 0, 0, 4'd0, 0, 0, 0, 1, 1, 0);
    e[2] = mk(0, 0, 0, 2'd3, 0, 1, 0, 1, 0, 4'd2, 0, 0, 0, 2, 1, 0);
    e[3] = mk(0, 0, 2'd2, 0, 1, 0, 0, 0, 1, 4'd0, 0, 0, 1, 3, 1, 0);
    e[4] = ZERO;
    for (int c = 0; c < 5; c++) begin
      go = (c == 0) || (c == 2);
      inst_in = (c >= 2) ? LD : ADD;
      #1;
      checks++;
      if (obs !== e[c]) begin errors++; $display("FAIL go_busy cyc%0d: got %h required %h", c, obs, e[c]); end
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [30:0] e [9];
    logic        g [9];
    logic        ec [9];
    int          n;
    e[0] = FETCH; g[0] = 1; ec[0] = 0;
`ifdef MULTICYCLE_CONTROLLER_ILLEGAL_TRAP_EN
    n = 9;
    e[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); g[1] = 1; ec[1] = 0;
    for (int c = 2; c < 7; c++) begin
      e[c] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); g[c] = 1; ec[c] = 0;
    end
    e[7] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); g[7] = 0; ec[7] = 1;
    e[8] = ZERO;                                               g[8] = 0; ec[8] = 0;
`else
    n = 3;
    e[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0); g[1] = 0; ec[1] = 1;
    e[2] = ZERO;                                               g[2] = 0; ec[2] = 1;
    for (int c = 3; c < 9; c++) begin
      e[c] = ZERO; g[c] = 0; ec[c] = 0;
    end
`endif
    for (int c = 0; c < n; c++) begin
      go = g[c]; err_clr = ec[c]; inst_in = ILL;
      #1;
      checks++;
      if (obs !== e[c]) begin errors++; $display("FAIL illegal cyc%0d: got %h required %h", c, obs, e[c]); end
      tick();
    end
    err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    go = 1'b1; inst_in = ADD;
    tick();
    go = 1'b0;
    tick();
    #1;
    checks++;
    if (T !== 2'd2) begin errors++; $display("FAIL rst_mid_pre T: got %0d required 2", T); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== ZERO) begin errors++; $display("FAIL rst_mid_async: got %h required %h", obs, ZERO); end
    tick();
    checks++;
    if (obs !== ZERO || ENW !== 1'b0) begin errors++; $display("FAIL rst_mid_next: got %h required %h", obs, ZERO); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (obs !== ZERO) begin errors++; $display("FAIL rst_mid_after: got %h required %h", obs, ZERO); end
  endtask

  initial begin
    test_reset();
    test_ld();
    test_add();
    test_subi();
    test_back_to_back();
    test_go_ignored();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
